// File: rtl/lab_alu_pkg.sv
// Shared codes for the register/ALU/transfer datapath: strobe modes, ALU
// operations and the bit positions of the {Z,N,C,V} flag word.
package lab_alu_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'b00,
    MODE_ALU   = 2'b01,
    MODE_XFER  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_NOR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/btn_strobe.sv
// Two-flop synchroniser plus history flop per button; emits a one-cycle
// strobe on each sampled rising edge. All flops reset high so a button held
// through reset never produces a strobe when reset is released.
module btn_strobe #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] strobe_o
);

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      hist_q  <= '1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign strobe_o = sync2_q & ~hist_q;

endmodule

// File: rtl/reg_transfer_alu.sv
// NREG-register datapath: each button strobe counts, writes an ALU result or
// transfers a register/zero into its register, according to the sampled mode.
module reg_transfer_alu
  import lab_alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREG  = 4,
  localparam int SELW  = $clog2(NREG) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREG-1:0]       btn,
  input  logic [1:0]            mode,
  input  logic [NREG-1:0]       dir,
  input  logic [2:0]            alu_op,
  input  logic [SELW-1:0]       src_a,
  input  logic [SELW-1:0]       src_b,
  output logic [NREG*WIDTH-1:0] regs,
  output logic [WIDTH-1:0]      res,
  output logic [3:0]            flags
);

  localparam int MSB = WIDTH - 1;

  logic [NREG-1:0]  strobe;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  flags_t           flags_q;
  flags_t           flags_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  btn_strobe #(.N(NREG)) u_btn_strobe (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn),
    .strobe_o (strobe)
  );

  // Any select value without a matching register falls through to zero.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == SELW'(i)) op_a = regs_q[i];
      if (src_b == SELW'(i)) op_b = regs_q[i];
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
        alu_v = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
        alu_v = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_PASS: alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  // Operands come from regs_q, so simultaneous strobes all see pre-edge values.
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    for (int i = 0; i < NREG; i++) begin
      if (strobe[i]) begin
        case (mode)
          MODE_COUNT: regs_d[i] = dir[i] ? regs_q[i] - WIDTH'(1) : regs_q[i] + WIDTH'(1);
          MODE_ALU:   regs_d[i] = alu_res;
          MODE_XFER:  regs_d[i] = op_a;
          default:    regs_d[i] = regs_q[i];
        endcase
      end
    end
    if ((|strobe) && (mode == MODE_ALU)) begin
      flags_d.z = (alu_res == '0);
      flags_d.n = alu_res[MSB];
      flags_d.c = alu_c;
      flags_d.v = alu_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_pack
    assign regs[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign res   = regs_q[0] + regs_q[1];
  assign flags = flags_q;

endmodule

// File: tb/tb_reg_transfer_alu.sv
// Bench for reg_transfer_alu: directed scenarios plus random strobe
// transactions against an integer-arithmetic reference model.
module tb_reg_transfer_alu;

  localparam int W    = 4;
  localparam int NREG = 4;
  localparam int SELW = $clog2(NREG) + 1;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic                 clk;
  logic                 rst;
  logic [NREG-1:0]      btn;
  logic [1:0]           mode;
  logic [NREG-1:0]      dir;
  logic [2:0]           alu_op;
  logic [SELW-1:0]      src_a;
  logic [SELW-1:0]      src_b;
  logic [NREG*W-1:0]    regs_w;
  logic [W-1:0]         res_w;
  logic [3:0]           flags_w;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int         m_r [NREG];
  logic [3:0] m_flags;

  reg_transfer_alu #(.WIDTH(W), .NREG(NREG)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .mode   (mode),
    .dir    (dir),
    .alu_op (alu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .regs   (regs_w),
    .res    (res_w),
    .flags  (flags_w)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_reg(input int i);
    return regs_w[i*W +: W];
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut_reg(i)), 32'(m_r[i]));
    check({tag, "_res"}, 32'(res_w), 32'((m_r[0] + m_r[1]) % MOD));
    check({tag, "_flags"}, 32'(flags_w), 32'(m_flags));
  endtask

  // ---------------- reference model ----------------
  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  function automatic int src_val(input int s);
    return (s < NREG) ? m_r[s] : 0;
  endfunction

  task automatic model_alu(input int a, input int b, input int op,
                           output int r, output logic [3:0] f);
    int sa, sb, t;
    logic c, v;
    sa = to_signed(a);
    sb = to_signed(b);
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin t = a + b; r = t % MOD; c = (t >= MOD);
               v = (sa + sb > HALF - 1) || (sa + sb < -HALF); end
      1: begin t = a - b; r = (t + MOD) % MOD; c = (a < b);
               v = (sa - sb > HALF - 1) || (sa - sb < -HALF); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (~(a | b)) & (MOD - 1);
      default: r = a;
    endcase
    f = {(r == 0), (r >= HALF), c, v};
  endtask

  task automatic model_apply(input logic [NREG-1:0] mask, input int m,
                             input logic [NREG-1:0] d, input int op,
                             input int sa, input int sb);
    int nxt [NREG];
    int r;
    logic [3:0] f;
    model_alu(src_val(sa), src_val(sb), op, r, f);
    for (int i = 0; i < NREG; i++) begin
      nxt[i] = m_r[i];
      if (mask[i]) begin
        if (m == 0)      nxt[i] = d[i] ? (m_r[i] + MOD - 1) % MOD : (m_r[i] + 1) % MOD;
        else if (m == 1) nxt[i] = r;
        else if (m == 2) nxt[i] = src_val(sa);
      end
    end
    for (int i = 0; i < NREG; i++) m_r[i] = nxt[i];
    if (m == 1 && mask != '0) m_flags = f;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_r[i] = 0;
    m_flags = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  // One-cycle button pulse with controls held stable until after the update.
  task automatic pulse(input logic [NREG-1:0] mask, input logic [1:0] m,
                       input logic [NREG-1:0] d, input logic [2:0] op,
                       input logic [SELW-1:0] sa, input logic [SELW-1:0] sb);
    @(negedge clk);
    mode = m; dir = d; alu_op = op; src_a = sa; src_b = sb;
    btn = mask;
    @(negedge clk);
    btn = '0;
    repeat (3) @(negedge clk);
    model_apply(mask, int'(m), d, int'(op), int'(sa), int'(sb));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; btn = '0; mode = 2'b00; dir = '0; alu_op = '0; src_a = '0; src_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Count
    pulse(4'b0001, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    repeat (3) pulse(4'b0010, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    check("cnt_r0", 32'(dut_reg(0)), 32'd1);
    check("cnt_r1", 32'(dut_reg(1)), 32'd3);
    pulse(4'b0010, 2'b00, 4'b0010, 3'd0, 3'd0, 3'd0);
    check("cnt_down_r1", 32'(dut_reg(1)), 32'd2);
    check("cnt_res", 32'(res_w), 32'd3);
    compare_all("count");

    // ALU into R2, A=R0=1, B=R1=2
    pulse(4'b0100, 2'b01, 4'b0000, 3'd0, 3'd0, 3'd1);
    check("add_r2", 32'(dut_reg(2)), 32'd3);
    check("add_flags", 32'(flags_w), 32'b0000);
    pulse(4'b0100, 2'b01, 4'b0000, 3'd1, 3'd0, 3'd1);
    check("sub_r2", 32'(dut_reg(2)), 32'hF);
    check("sub_flags", 32'(flags_w), 32'b0110);
    pulse(4'b0100, 2'b01, 4'b0000, 3'd2, 3'd0, 3'd1);
    check("and_flags", 32'(flags_w), 32'b1000);
    pulse(4'b0100, 2'b01, 4'b0000, 3'd3, 3'd0, 3'd1);
    check("or_r2", 32'(dut_reg(2)), 32'd3);
    compare_all("alu");

    // Transfer
    pulse(4'b0001, 2'b10, 4'b0000, 3'd0, 3'd2, 3'd0);
    check("xfer_res5", 32'(res_w), 32'd5);
    pulse(4'b0010, 2'b10, 4'b0000, 3'd0, 3'd4, 3'd0);
    check("xfer_zero_r1", 32'(dut_reg(1)), 32'd0);
    pulse(4'b1010, 2'b10, 4'b0000, 3'd0, 3'd0, 3'd0);
    check("xfer_multi_r3", 32'(dut_reg(3)), 32'd3);
    compare_all("xfer");

    // Wrap and overflow
    do_reset();
    pulse(4'b0001, 2'b00, 4'b0001, 3'd0, 3'd0, 3'd0);
    check("wrap_down", 32'(dut_reg(0)), 32'hF);
    pulse(4'b0001, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    check("wrap_up", 32'(dut_reg(0)), 32'h0);
    pulse(4'b0001, 2'b10, 4'b0000, 3'd0, 3'd4, 3'd0);
    repeat (7) pulse(4'b0001, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    pulse(4'b0010, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    pulse(4'b0100, 2'b01, 4'b0000, 3'd0, 3'd0, 3'd1);
    check("ovf_r2", 32'(dut_reg(2)), 32'h8);
    check("ovf_flags", 32'(flags_w), 32'b0101);
    pulse(4'b1000, 2'b00, 4'b1000, 3'd0, 3'd0, 3'd0);
    pulse(4'b0100, 2'b01, 4'b0000, 3'd0, 3'd3, 3'd3);
    check("carry_r2", 32'(dut_reg(2)), 32'hE);
    check("carry_flags", 32'(flags_w), 32'b0110);
    compare_all("wrap");

    // Hold mode consumes strobes
    pulse(4'b1111, 2'b11, 4'b0101, 3'd0, 3'd0, 3'd1);
    compare_all("hold");

    // Held button: one increment, exactly at edge k+2
    @(negedge clk);
    mode = 2'b00; dir = '0; btn = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) check("held_k1_unchanged", 32'(dut_reg(0)), 32'(m_r[0]));
      if (c == 3) begin
        model_apply(4'b0001, 0, 4'b0000, 0, 0, 0);
        check("held_k2_inc", 32'(dut_reg(0)), 32'(m_r[0]));
      end
    end
    btn = '0;
    repeat (4) @(negedge clk);
    compare_all("held");

    // Mode switched between rise and strobe edge: the strobe-edge mode wins
    @(negedge clk);
    mode = 2'b11; dir = '0; btn = 4'b0001;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    mode = 2'b00;
    repeat (3) @(negedge clk);
    model_apply(4'b0001, 0, 4'b0000, 0, 0, 0);
    compare_all("mode_sw_cnt");
    @(negedge clk);
    mode = 2'b00; btn = 4'b0010;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    mode = 2'b11;
    repeat (3) @(negedge clk);
    compare_all("mode_sw_hold");

    // Random transactions
    for (int t = 0; t < 200; t++) begin
      pulse(NREG'($urandom_range(0, MOD - 1)), 2'($urandom_range(0, 3)),
            NREG'($urandom_range(0, MOD - 1)), 3'($urandom_range(0, 7)),
            SELW'($urandom_range(0, 7)), SELW'($urandom_range(0, 7)));
      compare_all($sformatf("rnd%0d", t));
    end

    // Reset and strobe on the same edge
    @(negedge clk);
    mode = 2'b00; dir = '0; btn = 4'b1111;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all("rst_strobe");
    repeat (3) @(negedge clk);

    // Button held across reset release
    pulse(4'b0001, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    btn = 4'b1111; mode = 2'b00; dir = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
    compare_all("held_rst");
    pulse(4'b0001, 2'b00, 4'b0000, 3'd0, 3'd0, 3'd0);
    compare_all("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_transfer_alu.md
# reg_transfer_alu

Parametrised successor of the lab counter/ALU/transfer datapath. Holds NREG registers of WIDTH bits, each loaded by a debounced-free, synchronised button strobe; per the selected mode a strobe counts the register up/down, writes an ALU result, or transfers a register/zero into it. Fully synchronous to `clk` with button edge detection inside the block, so it replaces button-clocked register logic in the lab top level and drives the board's debug/display outputs.

## Interface
- `WIDTH`, 4, register and ALU width in bits (≥2)
- `NREG`, 4, number of registers (≥2)
- `SELW`, $clog2(NREG)+1, source-select width (derived, not overridden)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `btn`  in  NREG  raw button levels; bit i is the load strobe request for register i
- `mode`  in  2  00 count, 01 ALU, 10 transfer, 11 hold
- `dir`  in  NREG  per-register count direction: 0 up, 1 down
- `alu_op`  in  3  ALU operation (codes in package)
- `src_a`  in  SELW  operand A / transfer source; value ≥ NREG selects constant 0
- `src_b`  in  SELW  operand B; value ≥ NREG selects constant 0
- `regs`  out  NREG*WIDTH  register contents, R0 in bits [WIDTH-1:0]
- `res`  out  WIDTH  R0 + R1 mod 2^WIDTH, combinational from registers
- `flags`  out  4  {Z,N,C,V} of the last ALU writeback, registered

## Operation
- Each `btn[i]` passes a 2-flop synchroniser plus history flop; strobe[i] = sync2 & ~hist. One strobe per rising edge; a held button never retriggers until sampled low at least once.
- `mode`, `dir`, `alu_op`, `src_*` are sampled on the edge where the strobe is high.
- Count: every strobed register i increments (dir[i]=0) or decrements (dir[i]=1) independently; wraps 2^WIDTH-1→0 and 0→2^WIDTH-1. Flags unchanged.
- ALU: result = op(A,B); all strobed registers receive it; flags updated. Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed A<B → 1 else 0), 110 NOR, 111 PASS A. Arithmetic mod 2^WIDTH. ADD: C = carry-out, V = signed overflow. SUB: C = borrow (A<B unsigned), V = signed overflow. Logic/SLT/PASS: C=V=0. Z = result==0, N = result MSB.
- Transfer: all strobed registers ← source selected by `src_a` (zero if ≥ NREG). Self-transfer leaves value unchanged. Flags unchanged.
- Hold: strobes consumed, no state change.
- Simultaneous strobes: operands/sources read pre-edge values; all destinations written on the same edge.

## Timing
- Reset: all registers 0, `flags` 0, `res` 0; synchroniser and history flops reset to 1, so a button held across reset produces no strobe after release; a low button fires only on its next genuine rise.
- Reset has priority over any strobe on the same edge.
- Latency: `btn` first sampled high at edge k → register and flags updated at edge k+2; `res` follows the registers in the same cycle.
- Minimum button pulse: high across one rising edge; minimum low gap for retrigger: low across one rising edge.
- No backpressure, no busy: strobes arrive at most once per 2 cycles per button by construction.

## Structure
- Package `lab_alu_pkg`: mode codes, `alu_op` codes, flag bit positions.
- Sub-module `btn_strobe` (parameter N): synchroniser + rising-edge detector with reset-to-1 history; one instance over the `btn` vector.
- ALU as a pure function/always_comb in the top module; register array and writeback in the top.

## Test plan
- Count: reset, dir=0, one pulse btn[0], three pulses btn[1] → R0=1, R1=3; dir[1]=1, pulse btn[1] → R1=2, res=3.
- ALU with R0=1,R1=2, src_a=0, src_b=1, strobe btn[2]: ADD → R2=3, flags 0000; SUB → R2=F, N=1,C=1; AND → R2=0, Z=1; OR → R2=3.
- Transfer: src_a=2, btn[0] → R0=3, res=5; src_a=4 (zero), btn[1] → R1=0, res=3; btn[1]&btn[3] same edge with src_a=0 → R1=R3=3.
- Wrap/overflow: R0=0 dir=1 pulse → F; dir=0 pulse → 0; ADD 7+1 → 8, N=1,V=1; ADD F+F → E, C=1,V=0.
- Edge/reset: btn[0] held 10 cycles → exactly one increment at edge k+2; btn held across reset release → no change; reset and strobe same edge → all 0.
- Mode 11 with strobes → no change; mode switched on the strobe edge → new mode applied.
